chan_select_mux: RTL and testbench

Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshaking on every input and on the output. It generalises the fixed 6:1 4-bit selector to arbitrary width and channel count. It adds a round-robin scan mode for draining multiple producers into one consumer, and a sticky flag for out-of-range select values. It sits between per-channel producers and a single downstream consumer.

---
 rtl/chan_select_mux_if.sv | 31 +++
 rtl/chan_select_mux.sv | 100 ++++++++++
 tb/tb_chan_select_mux.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/chan_select_mux_if.sv
// Handshake bundle for chan_select_mux: per-channel producer inputs, the single
// consumer output, the select controls and the sticky select-error flag.
interface chan_select_mux_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 6,
    parameter int SEL_W    = 3
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;
    logic                      err_clr;
    logic                      err_sel;

    // Environment side: producers, consumer and control.
    modport master (
        output mode, sel, in_valid, in_data, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_chan, err_sel
    );

    // Selector side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_chan, err_sel
    );
endinterface

// File: rtl/chan_select_mux.sv
// N-channel W-bit selector with a single registered output slot, valid/ready on
// every port, direct or round-robin channel choice and a sticky bad-select flag.
module chan_select_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 6,
    parameter int SEL_W    = 3
) (
    input logic              clk,
    input logic              areset,
    chan_select_mux_if.slave bus
);
    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    chan_word [CHANNELS];
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic [SEL_W-1:0]    ptr;
    logic                err_sel_q;
    logic                can_accept;
    logic                sel_in_range;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant;
    logic [CHANNELS-1:0] ready;
    logic                xfer;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_word[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    assign can_accept   = !out_valid_q || bus.out_ready;
    assign sel_in_range = {1'b0, bus.sel} < CH_CNT;

    // Round-robin search starts at ptr and wraps explicitly at CHANNELS-1,
    // so non-power-of-two channel counts never land on a missing channel.
    always_comb begin
        logic [SEL_W:0] idx;
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        if (!bus.mode) begin
            if (sel_in_range) begin
                grant_valid = 1'b1;
                grant       = bus.sel;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = {1'b0, ptr} + (SEL_W + 1)'(k);
                if (idx >= CH_CNT) idx = idx - CH_CNT;
                if (!grant_valid && bus.in_valid[idx[SEL_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant       = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ready[i] = !areset && can_accept && grant_valid && (grant == SEL_W'(i));
        end
    end

    assign xfer = |(bus.in_valid & ready);

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr         <= '0;
            err_sel_q   <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= chan_word[grant];
                out_chan_q  <= grant;
                if (bus.mode) ptr <= (grant == LAST_CH) ? '0 : grant + SEL_W'(1);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A bad select on the same edge as a clear keeps the flag set.
            if (!bus.mode && !sel_in_range) err_sel_q <= 1'b1;
            else if (bus.err_clr)           err_sel_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.err_sel   = err_sel_q;
endmodule

// File: tb/tb_chan_select_mux.sv
// Directed bench for chan_select_mux: a 6x4 instance and a 3x8 instance driven
// through step sequences with hand-computed expectations.
module tb_chan_select_mux;
    logic clk = 1'b0;
    logic areset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    chan_select_mux_if #(.WIDTH(4), .CHANNELS(6), .SEL_W(3)) ia ();
    chan_select_mux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) ib ();

    chan_select_mux #(.WIDTH(4), .CHANNELS(6), .SEL_W(3)) dut_a (
        .clk(clk), .areset(areset), .bus(ia)
    );
    chan_select_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk(clk), .areset(areset), .bus(ib)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        areset = 1'b1;
        ia.mode = 1'b0; ia.sel = '0; ia.in_valid = '0; ia.in_data = '0;
        ia.out_ready = 1'b1; ia.err_clr = 1'b0;
        ib.mode = 1'b0; ib.sel = '0; ib.in_valid = '0; ib.in_data = '0;
        ib.out_ready = 1'b1; ib.err_clr = 1'b0;
        ia.in_valid = 6'b001000;
        ia.sel = 3'd3;

        // Reset: everything low, including the grant that would otherwise fire.
        tick; tick;
        check("rst_in_ready",  32'(ia.in_ready),  32'h0);
        check("rst_out_valid", 32'(ia.out_valid), 32'h0);
        check("rst_out_data",  32'(ia.out_data),  32'h0);
        check("rst_out_chan",  32'(ia.out_chan),  32'h0);
        check("rst_err_sel",   32'(ia.err_sel),   32'h0);
        check("rst_b_valid",   32'(ib.out_valid), 32'h0);
        ia.in_valid = '0;
        areset = 1'b0;

        // Direct select of channel 3.
        ia.mode = 1'b0; ia.sel = 3'd3; ia.in_valid = 6'b001000;
        ia.in_data = 24'h00A000; ia.out_ready = 1'b1;
        #1;
        check("dir_in_ready", 32'(ia.in_ready), 32'h08);
        tick;
        check("dir_out_valid", 32'(ia.out_valid), 32'h1);
        check("dir_out_data",  32'(ia.out_data),  32'hA);
        check("dir_out_chan",  32'(ia.out_chan),  32'h3);

        // Backpressure for three cycles, then no-bubble refill.
        ia.out_ready = 1'b0; ia.in_data = 24'h00B000;
        #1;
        check("bp_in_ready0", 32'(ia.in_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            check("bp_in_ready", 32'(ia.in_ready),  32'h0);
            check("bp_hold_data", 32'(ia.out_data), 32'hA);
            check("bp_hold_valid", 32'(ia.out_valid), 32'h1);
        end
        ia.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(ia.in_ready), 32'h08);
        tick;
        check("bp_next_valid", 32'(ia.out_valid), 32'h1);
        check("bp_next_data",  32'(ia.out_data),  32'hB);
        ia.in_valid = '0;
        tick;
        check("drain_valid", 32'(ia.out_valid), 32'h0);
        check("drain_hold_data", 32'(ia.out_data), 32'hB);

        // Round robin, all channels valid, data equals index.
        ia.mode = 1'b1; ia.in_valid = 6'b111111; ia.in_data = 24'h543210;
        for (int c = 0; c < 7; c++) begin
            tick;
            check("rr_all_chan",  32'(ia.out_chan), 32'(c % 6));
            check("rr_all_data",  32'(ia.out_data), 32'(c % 6));
            check("rr_all_valid", 32'(ia.out_valid), 32'h1);
        end

        // Round robin, only channels 1 and 4.
        ia.in_valid = 6'b010010;
        tick; check("rr14_0", 32'(ia.out_chan), 32'd1);
        tick; check("rr14_1", 32'(ia.out_chan), 32'd4);
        tick; check("rr14_2", 32'(ia.out_chan), 32'd1);
        tick; check("rr14_3", 32'(ia.out_chan), 32'd4);

        // Out-of-range select and the sticky flag.
        ia.mode = 1'b0; ia.sel = 3'd6; ia.in_valid = 6'b111111;
        #1;
        check("oor_in_ready", 32'(ia.in_ready), 32'h0);
        tick;
        check("oor_no_xfer", 32'(ia.out_valid), 32'h0);
        check("oor_err_set", 32'(ia.err_sel),   32'h1);
        ia.sel = 3'd2;
        tick;
        check("oor_err_sticky", 32'(ia.err_sel),  32'h1);
        check("oor_sel2_chan",  32'(ia.out_chan), 32'd2);
        ia.err_clr = 1'b1; ia.sel = 3'd7;
        tick;
        check("oor_set_wins", 32'(ia.err_sel), 32'h1);
        ia.sel = 3'd2;
        tick;
        check("oor_cleared", 32'(ia.err_sel), 32'h0);
        ia.err_clr = 1'b0;

        // Round robin resumes from the held pointer, then reset mid-stream.
        ia.mode = 1'b1;
        tick; check("rr_resume5", 32'(ia.out_chan), 32'd5);
        tick; check("rr_resume0", 32'(ia.out_chan), 32'd0);
        ia.out_ready = 1'b0;
        tick;
        check("mid_full_valid", 32'(ia.out_valid), 32'h1);
        check("mid_full_ready", 32'(ia.in_ready),  32'h0);
        #2;
        areset = 1'b1; ia.out_ready = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ia.out_valid), 32'h0);
        check("mid_rst_ptr",   32'(dut_a.ptr),     32'h0);
        check("mid_rst_ready", 32'(ia.in_ready),   32'h0);
        tick;
        areset = 1'b0;
        #1;
        check("post_rst_ready", 32'(ia.in_ready), 32'h01);
        tick;
        check("post_rst_chan0", 32'(ia.out_chan),  32'd0);
        check("post_rst_valid", 32'(ia.out_valid), 32'h1);
        tick;
        check("post_rst_chan1", 32'(ia.out_chan),  32'd1);

        // Parameter sweep: 3 channels, 8 bits, 2-bit select.
        ib.mode = 1'b0; ib.sel = 2'd3; ib.in_valid = 3'b111;
        ib.in_data = 24'h332211; ib.out_ready = 1'b1;
        #1;
        check("b_oor_ready", 32'(ib.in_ready), 32'h0);
        tick;
        check("b_oor_valid", 32'(ib.out_valid), 32'h0);
        check("b_oor_err",   32'(ib.err_sel),   32'h1);
        ib.sel = 2'd1;
        #1;
        check("b_dir_ready", 32'(ib.in_ready), 32'h2);
        tick;
        check("b_dir_data", 32'(ib.out_data), 32'h22);
        check("b_dir_chan", 32'(ib.out_chan), 32'd1);
        ib.err_clr = 1'b1;
        tick;
        check("b_err_clr", 32'(ib.err_sel), 32'h0);
        ib.err_clr = 1'b0;
        ib.mode = 1'b1;
        tick; check("b_rr0", 32'(ib.out_chan), 32'd0); check("b_rr0_d", 32'(ib.out_data), 32'h11);
        tick; check("b_rr1", 32'(ib.out_chan), 32'd1); check("b_rr1_d", 32'(ib.out_data), 32'h22);
        tick; check("b_rr2", 32'(ib.out_chan), 32'd2); check("b_rr2_d", 32'(ib.out_data), 32'h33);
        tick; check("b_rr3", 32'(ib.out_chan), 32'd0); check("b_rr3_d", 32'(ib.out_data), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
